// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks A/B in SLICE-bit slices, LSB first,
// so the most significant differing slice has the final say; seedable l/e/g cascade.
module seq_magnitude_comparator #(
    parameter int WIDTH = 12,
    parameter int SLICE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             et,
    output logic             gt
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Flag encoding is {less, equal, greater}, one-hot once loaded.
    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       flags_q, flags_d;
    logic [2:0]       res_q, res_d;
    logic [2:0]       seed;
    logic [SLICE-1:0] a_sl, b_sl;

    // Non-one-hot seeds collapse to "equal" so the cascade stays well-formed.
    assign seed = $onehot({l, e, g}) ? {l, e, g} : F_EQ;

    // Operands are shifted right each RUN cycle, so the active slice is always the low bits.
    assign a_sl = a_q[SLICE-1:0];
    assign b_sl = b_q[SLICE-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
        res_d   = res_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = A;
                    b_d     = B;
                    flags_d = seed;
                end
            end
            RUN: begin
                if (a_sl > b_sl)      flags_d = F_GT;
                else if (a_sl < b_sl) flags_d = F_LT;
                a_d = a_q >> SLICE;
                b_d = b_q >> SLICE;
                if (idx_q == IW'(NSLICE - 1)) begin
                    state_d = DONE;
                    res_d   = flags_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == RUN);
        done         = (state_q == DONE);
        {lt, et, gt} = res_q;
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized + directed bench for seq_magnitude_comparator against a whole-word reference model.
module tb_seq_magnitude_comparator;
    localparam int W      = 12;
    localparam int NSLICE = W / 3;

    logic         clk, reset, start, l, e, g;
    logic [W-1:0] A, B;
    logic         busy, done, lt, et, gt;
    logic [2:0]   exp_r;
    int           n_chk  = 0;
    int           n_pass = 0;

    seq_magnitude_comparator #(.WIDTH(W), .SLICE(3)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .l(l), .e(e), .g(g), .busy(busy), .done(done),
        .lt(lt), .et(et), .gt(gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Whole-word compare; the seed only matters when operands are equal.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] s);
        if (a > b) return 3'b001;
        if (a < b) return 3'b100;
        if (s == 3'b100 || s == 3'b010 || s == 3'b001) return s;
        return 3'b010;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        A = a; B = b; {l, e, g} = s; start = 1'b1;
        exp_r = model(a, b, s);
    endtask

    // Runs from the accepting edge through the DONE cycle; returns #1 into DONE.
    task automatic finish(input bit hold);
        tick;
        if (!hold) start = 1'b0;
        A = W'($urandom); B = W'($urandom); {l, e, g} = 3'($urandom);
        for (int i = 0; i < NSLICE; i++) begin
            chk("busy_run", {30'd0, busy, done}, 32'b10);
            if (i == NSLICE - 1) start = 1'b0;
            tick;
        end
        chk("done_pulse", {30'd0, busy, done}, 32'b01);
        chk("result", {29'd0, lt, et, gt}, {29'd0, exp_r});
    endtask

    task automatic idle_chk;
        tick;
        chk("idle_after", {27'd0, busy, done, lt, et, gt}, {27'd0, 2'b00, exp_r});
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input bit hold);
        apply(a, b, s);
        finish(hold);
        idle_chk;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; {l, e, g} = 3'b000;
        tick; tick;
        chk("reset_state", {27'd0, busy, done, lt, et, gt}, 32'd0);
        reset = 1'b0;
        tick;
        chk("idle_state", {27'd0, busy, done, lt, et, gt}, 32'd0);

        do_op(12'h001, 12'h001, 3'b010, 1'b0);
        do_op(12'h001, 12'h001, 3'b100, 1'b0);
        do_op(12'h001, 12'h001, 3'b001, 1'b0);
        do_op(12'h002, 12'h001, 3'b010, 1'b0);
        do_op(12'h001, 12'h002, 3'b001, 1'b0);
        do_op(12'h800, 12'h7FF, 3'b010, 1'b0);
        do_op(12'h3F8, 12'h400, 3'b010, 1'b0);
        do_op(12'h123, 12'h456, 3'b001, 1'b1);

        // Back-to-back: second start lands in the DONE cycle.
        apply(12'hABC, 12'hABC, 3'b100);
        finish(1'b0);
        apply(12'h0F0, 12'h00F, 3'b100);
        finish(1'b0);
        idle_chk;

        // Abort on the second RUN cycle.
        apply(12'h111, 12'h222, 3'b010);
        tick;
        start = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("reset_abort", {27'd0, busy, done, lt, et, gt}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < NSLICE + 2; i++) begin
            tick;
            chk("no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end
        do_op(12'h200, 12'h1FF, 3'b100, 1'b0);
        do_op(12'h555, 12'h555, 3'b110, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom % 4)
                0: rb = ra;
                1: rb = {ra[W-1:3], rb[2:0]};
                default: ;
            endcase
            apply(ra, rb, 3'($urandom));
            finish(1'($urandom));
            if ($urandom % 3 != 0) idle_chk;
        end
        idle_chk;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for wide unsigned operands.
- Walks the operands in 3-bit slices, LSB slice first, one slice per clock.
- Each slice decision overrides the running l/e/g flag only when the slice pair differs. This is the slice-to-slice cascade, generated internally rather than received.
- Sits on the datapath side of the lab comparator family. Delivers one-hot lt/et/gt with a start/busy/done handshake, and accepts an external cascade seed so results can chain across blocks.

Parameters:
- WIDTH, 12, operand width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 3, bits compared per clock; fixed at 3.
- NSLICE, WIDTH/SLICE (derived localparam), number of compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE and DONE.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- l  input  1  cascade seed "less"; sampled with A/B.
- e  input  1  cascade seed "equal"; sampled with A/B.
- g  input  1  cascade seed "greater"; sampled with A/B.
- busy  output  1  high while slices are being compared.
- done  output  1  one-cycle pulse; result valid.
- lt  output  1  A<B (or seed less with A==B).
- et  output  1  A==B with seed equal.
- gt  output  1  A>B (or seed greater with A==B).

Behaviour:
- Reset (sync, active-high, highest priority):
  - Next state IDLE; busy=0, done=0, lt=0, et=0, gt=0.
  - Slice index 0; operand and flag registers cleared.
  - Reset asserted mid-RUN aborts the comparison. No done is produced, and outputs return to 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches A, B and the seed into the internal flags.
  - Seed {l,e,g} must be one-hot. Any non-one-hot seed (000, 110, 111, ...) is loaded as equal (0,1,0).
  - Next state RUN, index 0.
- RUN, at index k, compare unsigned A[3k+2:3k] against B[3k+2:3k]:
  - A slice > B slice: flags = greater.
  - A slice < B slice: flags = less.
  - Slices equal: flags unchanged.
  - After index NSLICE-1, next state DONE; otherwise index increments.
  - Because the top slice is processed last, the most significant differing slice determines the result.
- DONE (one cycle):
  - done=1; lt/et/gt load the final flags on the edge entering DONE.
  - Next state IDLE, or RUN if start=1 in this cycle (back-to-back, with fresh operand and seed capture).
- busy=1 exactly in RUN. start while busy is ignored, and latched operands are unaffected by A/B changes during RUN.
- Latency: start sampled at edge t gives busy high for cycles t+1..t+NSLICE and done high in cycle t+NSLICE+1. For WIDTH=12 that is 4 busy cycles and done 5 cycles after start.
- lt/et/gt hold their value until the next DONE entry or reset, and are always one-hot after the first completion.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Equal operands, each seed, WIDTH=12: A=B=12'h001.
  - Seed {l,e,g}=010 -> et=1.
  - Seed 100 -> lt=1.
  - Seed 001 -> gt=1.
  - done pulses 1 cycle, 5 cycles after start; busy high 4 cycles.
- Unequal operands, seed ignored:
  - A=12'h002, B=12'h001, seed 010 -> gt=1.
  - A=12'h001, B=12'h002, seed 001 -> lt=1.
- MSB dominance:
  - A=12'h800, B=12'h7FF -> gt=1; lower slices favour B, the top slice overrides.
  - A=12'h3F8, B=12'h400 -> lt=1.
- Handshake:
  - start held during RUN with A/B changed mid-run -> ignored, and the result matches the originally latched operands.
  - start asserted in the DONE cycle -> busy rises next cycle; second done 5 cycles later with the new result.
- Reset mid-operation:
  - reset on the 2nd RUN cycle -> busy=0, done=0, lt/et/gt=0 next edge, and no done is produced.
  - A subsequent start works normally.
- Invalid seed: {l,e,g}=110 with A=B=12'h555 -> et=1.
